regfile_wb_arbiter: RTL and testbench



---
 rtl/wb_pkg.sv | 14 +
 rtl/regfile_wb_arbiter_if.sv | 27 ++
 rtl/wb_fifo.sv | 67 ++++++
 rtl/regfile_wb_arbiter.sv | 145 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file writeback arbiter.
package wb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: pipeline source, long-latency source, stall and the RF write port.
interface regfile_wb_arbiter_if;
  import wb_pkg::*;

  logic                  pipe_wr_en;
  logic [REG_ADDR_W-1:0] pipe_wr_addr;
  logic [DATA_W-1:0]     pipe_wr_data;
  logic                  lq_valid;
  logic                  lq_ready;
  logic [REG_ADDR_W-1:0] lq_addr;
  logic [DATA_W-1:0]     lq_data;
  logic                  pipe_stall;
  logic [REG_ADDR_W-1:0] write_address;
  logic [DATA_W-1:0]     write_data;
  logic                  CTRL_RegWrite;

  modport master (
    output pipe_wr_en, pipe_wr_addr, pipe_wr_data, lq_valid, lq_addr, lq_data,
    input  lq_ready, pipe_stall, write_address, write_data, CTRL_RegWrite
  );

  modport slave (
    input  pipe_wr_en, pipe_wr_addr, pipe_wr_data, lq_valid, lq_addr, lq_data,
    output lq_ready, pipe_stall, write_address, write_data, CTRL_RegWrite
  );

endinterface

// File: rtl/wb_fifo.sv
// In-order FIFO of pending long-latency writes; exposes per-entry valid/addr for the scoreboard.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 push,
  input  wb_entry_t                            push_entry,
  input  logic                                 pop,
  output wb_entry_t                            head,
  output logic                                 full,
  output logic                                 empty,
  output logic [DEPTH-1:0]                     ent_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]     ent_addr
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_entry_t [DEPTH-1:0] mem_q;
  logic [DEPTH-1:0]      valid_q;
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    ent_valid = valid_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_addr[i] = mem_q[i].addr;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      if (pop_ok) begin
        rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
        valid_q[rd_ptr_q] <= 1'b0;
      end
      if (push_ok) begin
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
        valid_q[wr_ptr_q] <= 1'b1;
      end
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback wins, long-latency results queue behind it.
// Optional macro WB_FWD_EN adds commit-cycle forwarding ports for the scoreboard queries.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_wb_arbiter_if.slave   wb,
  input  logic [REG_ADDR_W-1:0] rd_addr1,
  input  logic [REG_ADDR_W-1:0] rd_addr2,
  output logic                  rd_busy1,
  output logic                  rd_busy2
`ifdef WB_FWD_EN
  ,
  output logic                  fwd_valid1,
  output logic                  fwd_valid2,
  output logic [DATA_W-1:0]     fwd_data1,
  output logic [DATA_W-1:0]     fwd_data2
`endif
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic                           pipe_sel;
  logic                           fifo_push;
  logic                           fifo_pop;
  logic                           fifo_full;
  logic                           fifo_empty;
  wb_entry_t                      fifo_head;
  wb_entry_t                      lq_entry;
  logic [DEPTH-1:0]               ent_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_addr;

  logic                  out_we_q, out_we_nxt;
  logic [REG_ADDR_W-1:0] out_addr_q, out_addr_nxt;
  logic [DATA_W-1:0]     out_data_q, out_data_nxt;
  logic [STARVE_W-1:0]   starve_q, starve_nxt;
  logic                  stall_q, stall_nxt;

  logic hit1, hit2, out_hit1, out_hit2, nz1, nz2;

  assign lq_entry  = '{addr: wb.lq_addr, data: wb.lq_data};
  assign pipe_sel  = wb.pipe_wr_en && (wb.pipe_wr_addr != ZERO_REG);
  assign fifo_push = wb.lq_valid && !fifo_full && (wb.lq_addr != ZERO_REG);
  assign fifo_pop  = !pipe_sel && !fifo_empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .push_entry (lq_entry),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .ent_valid  (ent_valid),
    .ent_addr   (ent_addr)
  );

  // Output-stage selection and starvation tracking.
  always_comb begin
    out_we_nxt   = 1'b0;
    out_addr_nxt = out_addr_q;
    out_data_nxt = out_data_q;
    starve_nxt   = starve_q;
    if (pipe_sel) begin
      out_we_nxt   = 1'b1;
      out_addr_nxt = wb.pipe_wr_addr;
      out_data_nxt = wb.pipe_wr_data;
    end else if (fifo_pop) begin
      out_we_nxt   = 1'b1;
      out_addr_nxt = fifo_head.addr;
      out_data_nxt = fifo_head.data;
    end
    if (starve_q == STARVE_W'(STARVE_LIMIT)) begin
      starve_nxt = '0;
    end else if (fifo_empty || fifo_pop) begin
      starve_nxt = '0;
    end else if (pipe_sel) begin
      starve_nxt = starve_q + STARVE_W'(1);
    end
    stall_nxt = (starve_nxt == STARVE_W'(STARVE_LIMIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_we_q   <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
      starve_q   <= '0;
      stall_q    <= 1'b0;
    end else begin
      out_we_q   <= out_we_nxt;
      out_addr_q <= out_addr_nxt;
      out_data_q <= out_data_nxt;
      starve_q   <= starve_nxt;
      stall_q    <= stall_nxt;
    end
  end

  assign wb.lq_ready      = !fifo_full;
  assign wb.pipe_stall    = stall_q;
  assign wb.write_address = out_addr_q;
  assign wb.write_data    = out_data_q;
  assign wb.CTRL_RegWrite = out_we_q;

  // Scoreboard compare against queued entries and the committing output stage.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_addr[i] == rd_addr1)) hit1 = 1'b1;
      if (ent_valid[i] && (ent_addr[i] == rd_addr2)) hit2 = 1'b1;
    end
  end

  assign nz1      = (rd_addr1 != ZERO_REG);
  assign nz2      = (rd_addr2 != ZERO_REG);
  assign out_hit1 = out_we_q && (out_addr_q == rd_addr1);
  assign out_hit2 = out_we_q && (out_addr_q == rd_addr2);

`ifdef WB_FWD_EN
  // The committing value is forwarded, so only queued writes keep decode stalled.
  assign rd_busy1   = nz1 && hit1;
  assign rd_busy2   = nz2 && hit2;
  assign fwd_valid1 = nz1 && out_hit1;
  assign fwd_valid2 = nz2 && out_hit2;
  assign fwd_data1  = out_data_q;
  assign fwd_data2  = out_data_q;
`else
  assign rd_busy1 = nz1 && (hit1 || out_hit1);
  assign rd_busy2 = nz2 && (hit2 || out_hit2);
`endif

  // The pipeline is required to hold off while a stall is signalled.
  always @(posedge clk) begin
    if (rst_n && stall_q) begin
      assert (!wb.pipe_wr_en) else $error("pipeline writeback issued during pipe_stall");
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed + randomized bench for regfile_wb_arbiter against a queue-based reference model.
module tb_regfile_wb_arbiter;
  import wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic [REG_ADDR_W-1:0] rd_addr1, rd_addr2;
  logic rd_busy1, rd_busy2;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb       (bus),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_busy1 (rd_busy1),
    .rd_busy2 (rd_busy2)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: pending queue, committing write, length of current blocked run.
  wb_entry_t q[$];
  bit        m_we;
  logic [REG_ADDR_W-1:0] m_wa;
  logic [DATA_W-1:0]     m_wd;
  int        m_run;
  bit        m_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_busy(input logic [REG_ADDR_W-1:0] a);
    if (a == 0) return 1'b0;
    if (m_we && m_wa == a) return 1'b1;
    foreach (q[i]) if (q[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    q.delete();
    m_we = 0; m_wa = '0; m_wd = '0; m_run = 0; m_stall = 0;
  endtask

  task automatic check_all();
    check("we", bus.CTRL_RegWrite, m_we);
    if (m_we) begin
      check("waddr", bus.write_address, m_wa);
      check("wdata", bus.write_data, m_wd);
    end
    check("stall", bus.pipe_stall, m_stall);
    check("ready", bus.lq_ready, q.size() < DEPTH);
    check("busy1", rd_busy1, exp_busy(rd_addr1));
    check("busy2", rd_busy2, exp_busy(rd_addr2));
  endtask

  task automatic drive(input bit pe, input int pa, input int pd, input bit lv, input int la, input int ld);
    bus.pipe_wr_en   = pe;
    bus.pipe_wr_addr = REG_ADDR_W'(pa);
    bus.pipe_wr_data = DATA_W'(pd);
    bus.lq_valid     = lv;
    bus.lq_addr      = REG_ADDR_W'(la);
    bus.lq_data      = DATA_W'(ld);
  endtask

  // One clock: decide from current inputs, advance the model, then compare.
  task automatic step();
    bit psel, push, pop, blocked;
    wb_entry_t e;
    psel    = bus.pipe_wr_en && bus.pipe_wr_addr != 0;
    push    = bus.lq_valid && bus.lq_addr != 0 && q.size() < DEPTH;
    pop     = !psel && q.size() != 0;
    blocked = psel && q.size() != 0;
    e       = '{addr: bus.lq_addr, data: bus.lq_data};
    @(posedge clk);
    if (psel) begin
      m_we = 1; m_wa = bus.pipe_wr_addr; m_wd = bus.pipe_wr_data;
    end else if (pop) begin
      m_we = 1; m_wa = q[0].addr; m_wd = q[0].data;
      void'(q.pop_front());
    end else m_we = 0;
    if (push) q.push_back(e);
    if (m_stall) m_run = 0;
    else m_run = blocked ? m_run + 1 : 0;
    m_stall = (m_run == LIMIT);
    #1;
    check_all();
  endtask

  initial begin
    int stall_at, stall_cnt;
    rst_n = 1'b0;
    rd_addr1 = 5'd9; rd_addr2 = 5'd5;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", bus.CTRL_RegWrite, 0);
    check("rst_wa", bus.write_address, 0);
    check("rst_wd", bus.write_data, 0);
    check("rst_stall", bus.pipe_stall, 0);
    check("rst_ready", bus.lq_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Pipeline write r5 then idle.
    drive(1, 5, 32'h1234, 0, 0, 0);
    step();
    check("p5_addr", bus.write_address, 5);
    check("p5_data", bus.write_data, 32'h1234);
    check("p5_we", bus.CTRL_RegWrite, 1);
    drive(0, 0, 0, 0, 0, 0);
    step();
    check("p5_idle_we", bus.CTRL_RegWrite, 0);

    // Long-latency r9 with idle pipeline: commit two cycles after acceptance.
    drive(0, 0, 0, 1, 9, 32'hAAAA);
    step();
    drive(0, 0, 0, 0, 0, 0);
    check("lq9_busy_a", rd_busy1, 1);
    check("lq9_we_a", bus.CTRL_RegWrite, 0);
    step();
    check("lq9_we_b", bus.CTRL_RegWrite, 1);
    check("lq9_addr", bus.write_address, 9);
    check("lq9_data", bus.write_data, 32'hAAAA);
    check("lq9_busy_b", rd_busy1, 1);
    step();
    check("lq9_busy_c", rd_busy1, 0);

    // Fill FIFO under continuous pipeline writes; expect a single stall in cycle 10.
    stall_at = 0; stall_cnt = 0;
    rd_addr1 = 5'd10; rd_addr2 = 5'd13;
    for (int c = 1; c <= 14; c++) begin
      if (bus.pipe_stall) begin
        stall_cnt++;
        stall_at = c;
      end
      drive(!bus.pipe_stall, 1 + (c % 4), 32'h100 + c, c <= 4, 9 + c, 32'hB00 + c);
      step();
      if (c == 4) check("full_ready", bus.lq_ready, 0);
    end
    check("stall_cnt", stall_cnt, 1);
    check("stall_at", stall_at, 10);
    drive(0, 0, 0, 0, 0, 0);
    repeat (5) step();

    // Writes to r0 from both sources are dropped.
    rd_addr1 = 5'd0;
    drive(1, 0, 32'hFFFF, 1, 0, 32'hFFFF);
    step();
    check("r0_we", bus.CTRL_RegWrite, 0);
    check("r0_busy", rd_busy1, 0);
    drive(0, 0, 0, 0, 0, 0);
    step();
    check("r0_we2", bus.CTRL_RegWrite, 0);

    // Full FIFO: pop with lq_valid held, push lands only the next cycle.
    for (int c = 0; c < 4; c++) begin
      drive(1, 3, c, 1, 20 + c, 32'hC00 + c);
      step();
    end
    rd_addr2 = 5'd24;
    drive(0, 0, 0, 1, 24, 32'hD24);
    check("fullpop_ready", bus.lq_ready, 0);
    step();
    check("fullpop_busy", rd_busy2, 0);
    check("after_ready", bus.lq_ready, 1);
    step();
    check("after_busy", rd_busy2, 1);
    drive(0, 0, 0, 0, 0, 0);
    repeat (6) step();

    // Randomized traffic that respects pipe_stall.
    for (int c = 0; c < 400; c++) begin
      drive(!bus.pipe_stall && ($urandom_range(0, 99) < 55), $urandom_range(0, 31), $urandom,
            $urandom_range(0, 1), $urandom_range(0, 31), $urandom);
      rd_addr1 = REG_ADDR_W'($urandom_range(0, 31));
      rd_addr2 = (q.size() != 0) ? q[$urandom_range(0, q.size() - 1)].addr
                                 : REG_ADDR_W'($urandom_range(0, 31));
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (6) step();

    // Reset with three queued entries.
    for (int c = 0; c < 3; c++) begin
      drive(!bus.pipe_stall, 2, c, 1, 28 + c, 32'hE00 + c);
      step();
    end
    rd_addr1 = 5'd28; rd_addr2 = 5'd2;
    drive(0, 0, 0, 1, 17, 32'h17);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("mrst_we", bus.CTRL_RegWrite, 0);
    check("mrst_wa", bus.write_address, 0);
    check("mrst_busy1", rd_busy1, 0);
    check("mrst_ready", bus.lq_ready, 1);
    @(posedge clk);
    #1;
    check("mrst_hold_we", bus.CTRL_RegWrite, 0);
    check("mrst_hold_ready", bus.lq_ready, 1);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) step();
    check("post_rst_busy", rd_busy1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
